of_hazard_ctrl: RTL



---
 rtl/of_hazard_pkg.sv | 29 ++
 rtl/of_hazard_queue.sv | 101 ++++++++++
 rtl/of_hazard_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/of_hazard_pkg.sv
// -----------------------------------------------------------------------------
// of_hazard_pkg
// Shared definitions for the operand-fetch interlock controller.
//   OF_REG_AW     register address width (32 registers)
//   OF_DEPTH_DEF  default number of in-flight instructions past OF
//   of_entry_t    one in-flight queue entry {rd, wb}
//   ptr_w/cnt_w   pointer and count widths for a queue of a given depth
// -----------------------------------------------------------------------------
package of_hazard_pkg;

    localparam int OF_REG_AW    = 5;
    localparam int OF_DEPTH_DEF = 4;

    typedef struct packed {
        logic [OF_REG_AW-1:0] rd;
        logic                 wb;
    } of_entry_t;

    // Pointer width: indexes DEPTH slots (DEPTH is a power of two).
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Count width: one extra bit so that count==DEPTH is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/of_hazard_queue.sv
// -----------------------------------------------------------------------------
// of_hazard_queue
// In-order circular buffer of instructions that have left OF but not yet
// written back. Every slot is compared against both OF source addresses in
// parallel, so storage is held in flops rather than RAM.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push/push_rd/wb   append an entry at the tail
//   pop               remove the head entry (caller guarantees count != 0)
//   drop_req          number of youngest entries to remove (clamped to the
//                     count remaining after the pop)
//   addr1/addr2       source addresses to match against
//   head_rd/head_wb   contents of the head slot
//   count             number of valid entries
//   match1/match2     per-slot: valid & wb & rd==addr
//   head_sel          one-hot slot index of the head
// Same-cycle ordering: pop at head, then drop at tail, then push.
// -----------------------------------------------------------------------------
module of_hazard_queue
    import of_hazard_pkg::*;
#(
    parameter int DEPTH  = OF_DEPTH_DEF,
    parameter int REG_AW = OF_REG_AW,
    localparam int PW    = ptr_w(DEPTH),
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [REG_AW-1:0] push_rd,
    input  logic              push_wb,
    input  logic              pop,
    input  logic [1:0]        drop_req,
    input  logic [REG_AW-1:0] addr1,
    input  logic [REG_AW-1:0] addr2,
    output logic [REG_AW-1:0] head_rd,
    output logic              head_wb,
    output logic [CW-1:0]     count,
    output logic [DEPTH-1:0]  match1,
    output logic [DEPTH-1:0]  match2,
    output logic [DEPTH-1:0]  head_sel
);

    logic [REG_AW-1:0] rd_mem [DEPTH];
    logic [DEPTH-1:0]  wb_mem;
    logic [DEPTH-1:0]  valid_vec;

    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] count_pop, drop_ext, drop_n;

    always_comb begin
        count_pop  = count_reg - (pop ? CW'(1) : CW'(0));
        drop_ext   = CW'(drop_req);
        // Never drop more than what is left after the retire.
        drop_n     = (drop_ext < count_pop) ? drop_ext : count_pop;
        head_next  = head_reg + (pop ? PW'(1) : PW'(0));
        // Truncating drop_n to PW bits is exact modulo DEPTH.
        tail_next  = tail_reg - drop_n[PW-1:0] + (push ? PW'(1) : PW'(0));
        count_next = count_pop - drop_n + (push ? CW'(1) : CW'(0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Push is never concurrent with a drop, so the write slot is the current tail.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail_reg] <= push_rd;
            wb_mem[tail_reg] <= push_wb;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PW-1:0] offset;
            // Distance from head (mod DEPTH); slot is live if it is within count.
            assign offset        = PW'(gi) - head_reg;
            assign valid_vec[gi] = ({1'b0, offset} < count_reg);
            assign match1[gi]    = valid_vec[gi] & wb_mem[gi] & (rd_mem[gi] == addr1);
            assign match2[gi]    = valid_vec[gi] & wb_mem[gi] & (rd_mem[gi] == addr2);
            assign head_sel[gi]  = (head_reg == PW'(gi));
        end
    endgenerate

    assign head_rd = rd_mem[head_reg];
    assign head_wb = wb_mem[head_reg];
    assign count   = count_reg;

endmodule

// File: rtl/of_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// of_hazard_ctrl
// Operand-fetch interlock: tracks instructions between OF and register
// write-back and stalls OF while a real source has a pending write.
// Optional build macro: OF_WB_BYPASS_EN -- when defined, a source whose only
// pending writer is the instruction retiring this cycle takes WriteData
// (byp1/byp2) instead of stalling one more cycle.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   of_valid/of_rd/of_isWb  OF instruction and its destination
//   of_RP1/of_RP2           source addresses; of_use1/of_use2 mark real sources
//   flush/flush_cnt         squash the flush_cnt youngest in-flight entries
//   rw_valid/rw_isWb/WP     instruction leaving RW and its write port
//   stall/issue             OF hold / advance strobes (combinational)
//   byp1/byp2               source n takes WriteData (bypass build only)
//   occupancy               valid queue entries
//   err                     sticky retire protocol error, cleared by reset
// -----------------------------------------------------------------------------
module of_hazard_ctrl
    import of_hazard_pkg::*;
#(
    parameter int DEPTH  = OF_DEPTH_DEF,
    parameter int REG_AW = OF_REG_AW,
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              of_valid,
    input  logic [REG_AW-1:0] of_rd,
    input  logic              of_isWb,
    input  logic [REG_AW-1:0] of_RP1,
    input  logic [REG_AW-1:0] of_RP2,
    input  logic              of_use1,
    input  logic              of_use2,
    input  logic              flush,
    input  logic [1:0]        flush_cnt,
    input  logic              rw_valid,
    input  logic              rw_isWb,
    input  logic [REG_AW-1:0] WP,
    output logic              stall,
    output logic              issue,
    output logic              byp1,
    output logic              byp2,
    output logic [CW-1:0]     occupancy,
    output logic              err
);

    logic [REG_AW-1:0] head_rd;
    logic              head_wb;
    logic [CW-1:0]     count;
    logic [DEPTH-1:0]  match1, match2, head_sel;
    logic [DEPTH-1:0]  excl1, excl2;
    logic              pop_ok, full, hazard1, hazard2;
    logic              stall_c, issue_c, bad_retire;
    logic              err_reg;

    of_hazard_queue #(
        .DEPTH  (DEPTH),
        .REG_AW (REG_AW)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (issue_c),
        .push_rd  (of_rd),
        .push_wb  (of_isWb),
        .pop      (pop_ok),
        .drop_req (flush ? flush_cnt : 2'b00),
        .addr1    (of_RP1),
        .addr2    (of_RP2),
        .head_rd  (head_rd),
        .head_wb  (head_wb),
        .count    (count),
        .match1   (match1),
        .match2   (match2),
        .head_sel (head_sel)
    );

`ifdef OF_WB_BYPASS_EN
    assign byp1 = rw_valid & rw_isWb & (WP == of_RP1) & of_use1;
    assign byp2 = rw_valid & rw_isWb & (WP == of_RP2) & of_use2;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // A bypassed port ignores the head entry only; younger writers still stall.
    assign excl1   = byp1 ? head_sel : '0;
    assign excl2   = byp2 ? head_sel : '0;
    assign hazard1 = of_use1 & (|(match1 & ~excl1));
    assign hazard2 = of_use2 & (|(match2 & ~excl2));

    assign full    = (count == CW'(DEPTH));
    assign stall_c = of_valid & (hazard1 | hazard2 | full) & ~flush;
    assign issue_c = of_valid & ~stall_c & ~flush;

    // Retiring from an empty queue does nothing to the queue but is flagged.
    assign pop_ok     = rw_valid & (count != '0);
    assign bad_retire = (rw_valid & (count == '0))
                      | (pop_ok & ((rw_isWb != head_wb) | (rw_isWb & (WP != head_rd))));

    always_ff @(posedge clk) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (bad_retire) begin
            err_reg <= 1'b1;
        end
    end

    assign stall     = stall_c;
    assign issue     = issue_c;
    assign occupancy = count;
    assign err       = err_reg;

endmodule
